// File: rtl/cm_pkg.sv
// cm_pkg: shared types and helpers for the cm_sort scheduler.
//   cm_tag_t  - per-job tag {vld, id, cnt} carried alongside the sorter pipeline
//   cnt_width - width of a lane-count field able to hold 0..lanes
package cm_pkg;

    // Wide enough for up to 16 requesters and 255 lanes.
    localparam int unsigned ID_W      = 4;
    localparam int unsigned TAG_CNT_W = 8;

    typedef struct packed {
        logic                 vld;
        logic [ID_W-1:0]      id;
        logic [TAG_CNT_W-1:0] cnt;
    } cm_tag_t;

    function automatic int unsigned cnt_width(input int unsigned lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/cm_rr_arb.sv
// cm_rr_arb: round-robin arbiter.
//   clk_i     - clock
//   rst_i     - synchronous active-high reset (pointer back to 0)
//   req_i     - per-requester request
//   accept_i  - strobe: the current grant was taken this cycle
//   gnt_o     - one-hot grant (combinational), zero when no request
//   gnt_idx_o - binary index of the granted requester
// The search starts at ptr_q, which always points one past the last accepted grant.
module cm_rr_arb #(
    parameter int unsigned  REQ_CNT = 4,
    localparam int unsigned IW      = $clog2(REQ_CNT)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [REQ_CNT-1:0] req_i,
    input  logic               accept_i,
    output logic [REQ_CNT-1:0] gnt_o,
    output logic [IW-1:0]      gnt_idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int unsigned off = 0; off < REQ_CNT; off++) begin
            int unsigned idx;
            idx = (32'(ptr_q) + off) % REQ_CNT;
            if (!found && req_i[idx]) begin
                found          = 1'b1;
                gnt_o[idx]     = 1'b1;
                gnt_idx_o      = IW'(idx);
            end
        end
    end

    // Pointer moves only on a real transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (gnt_idx_o == IW'(REQ_CNT - 1)) ? '0 : gnt_idx_o + IW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cm_sort_sched.sv
// cm_sort_sched: shares one cm_sort pipeline among REQ_CNT requesters.
//   i_clk, i_rst            - clock, synchronous active-high reset
//   i_en                    - allow new grants (in-flight jobs always drain)
//   i_req_vld/o_req_rdy     - per-requester handshake, rdy one-hot or zero
//   i_req_data/i_req_cnt    - per-requester vector and valid-lane count
//   o_srt_vld/o_srt_data    - registered issue to cm_sort
//   i_srt_vld/i_srt_data    - result from cm_sort, LAT cycles after issue
//   o_rsp_vld               - one-hot response strobe to the owning requester
//   o_rsp_data/o_rsp_cnt    - shared result bus and job lane count
//   o_busy                  - any job in flight
//   o_err                   - sticky: sorter output and tag line disagreed
// cm_sort has no backpressure, so a plain LAT-deep tag shift register tracks ownership.
module cm_sort_sched
    import cm_pkg::*;
#(
    parameter int unsigned  REQ_CNT    = 4,
    parameter int unsigned  DATA_CNT   = 8,
    parameter int unsigned  DATA_WIDTH = 16,
    parameter int unsigned  LAT        = 4,
    localparam int unsigned CW         = cnt_width(DATA_CNT),
    localparam int unsigned IW         = $clog2(REQ_CNT)
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst,
    input  logic                                             i_en,
    input  logic [REQ_CNT-1:0]                               i_req_vld,
    output logic [REQ_CNT-1:0]                               o_req_rdy,
    input  logic [REQ_CNT-1:0][DATA_CNT-1:0][DATA_WIDTH-1:0] i_req_data,
    input  logic [REQ_CNT-1:0][CW-1:0]                       i_req_cnt,
    output logic                                             o_srt_vld,
    output logic [DATA_CNT-1:0][DATA_WIDTH-1:0]              o_srt_data,
    input  logic                                             i_srt_vld,
    input  logic [DATA_CNT-1:0][DATA_WIDTH-1:0]              i_srt_data,
    output logic [REQ_CNT-1:0]                               o_rsp_vld,
    output logic [DATA_CNT-1:0][DATA_WIDTH-1:0]              o_rsp_data,
    output logic [CW-1:0]                                    o_rsp_cnt,
    output logic                                             o_busy,
    output logic                                             o_err
);

    logic [REQ_CNT-1:0]                  arb_req;
    logic [REQ_CNT-1:0]                  gnt;
    logic [IW-1:0]                       gnt_idx;
    logic                                accept;

    logic [CW-1:0]                       sel_cnt;
    logic [CW-1:0]                       cnt_cl;
    logic [DATA_CNT-1:0][DATA_WIDTH-1:0] lane_d;
    cm_tag_t                             iss_tag_d, iss_tag_q;
    logic [DATA_CNT-1:0][DATA_WIDTH-1:0] srt_data_q;

    cm_tag_t [LAT-1:0]                   tag_q;
    cm_tag_t                             emerge;
    logic                                hit;
    logic                                busy_any;
    logic                                err_d, err_q;

    // ------------------------------------------------------------------
    // Arbitration: i_en gates requests so the pointer cannot move while disabled.
    // ------------------------------------------------------------------
    assign arb_req = i_req_vld & {REQ_CNT{i_en}};

    cm_rr_arb #(
        .REQ_CNT (REQ_CNT)
    ) u_arb (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .req_i     (arb_req),
        .accept_i  (accept),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign o_req_rdy = gnt & {REQ_CNT{~i_rst}};
    // rdy is only ever set for a requester that is also valid.
    assign accept    = |o_req_rdy;

    // ------------------------------------------------------------------
    // Issue stage: clamp count, pad unused lanes with all-ones so they sort last.
    // ------------------------------------------------------------------
    always_comb begin
        sel_cnt = i_req_cnt[gnt_idx];
        cnt_cl  = (sel_cnt > CW'(DATA_CNT)) ? CW'(DATA_CNT) : sel_cnt;
        lane_d  = '1;
        for (int unsigned j = 0; j < DATA_CNT; j++) begin
            if (CW'(j) < cnt_cl) begin
                lane_d[j] = i_req_data[gnt_idx][j];
            end
        end
        iss_tag_d     = '0;
        iss_tag_d.vld = accept;
        iss_tag_d.id  = ID_W'(gnt_idx);
        iss_tag_d.cnt = TAG_CNT_W'(cnt_cl);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            iss_tag_q  <= '0;
            srt_data_q <= '0;
        end else begin
            iss_tag_q <= iss_tag_d;
            if (accept) begin
                srt_data_q <= lane_d;
            end
        end
    end

    assign o_srt_vld  = iss_tag_q.vld & ~i_rst;
    assign o_srt_data = srt_data_q;

    // ------------------------------------------------------------------
    // Tag line: entry 0 loads in the cycle the job is presented to cm_sort,
    // so entry LAT-1 lines up with the matching i_srt_vld.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= iss_tag_q;
            for (int unsigned i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign emerge = tag_q[LAT-1];

    // ------------------------------------------------------------------
    // Response and error.
    // ------------------------------------------------------------------
    assign hit = i_srt_vld & emerge.vld & ~i_rst;

    always_comb begin
        o_rsp_vld = '0;
        for (int unsigned r = 0; r < REQ_CNT; r++) begin
            o_rsp_vld[r] = hit && (emerge.id == ID_W'(r));
        end
    end

    assign o_rsp_data = i_srt_data;
    assign o_rsp_cnt  = CW'(emerge.cnt);

    assign err_d = err_q | (i_srt_vld ^ emerge.vld);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q & ~i_rst;

    always_comb begin
        busy_any = iss_tag_q.vld;
        for (int unsigned i = 0; i < LAT; i++) begin
            busy_any = busy_any | tag_q[i].vld;
        end
    end

    assign o_busy = busy_any & ~i_rst;

endmodule

// File: doc/cm_sort_sched.md
CM_SORT_SCHED -- requirements
Module: cm_sort_sched

Interface
REQ-001 Parameter REQ_CNT, default 4, number of requesters sharing one cm_sort instance (2..16).
REQ-002 Parameter DATA_CNT, default 8, lanes per sort vector; shall equal the DATA_CNT of the attached cm_sort.
REQ-003 Parameter DATA_WIDTH, default 16, bits per lane.
REQ-004 Parameter LAT, default 4, cycles from cm_sort i_vld to o_vld; shall match the attached cm_sort configuration (1..32).
REQ-005 i_clk  in  1  single clock; all logic on rising edge.
REQ-006 i_rst  in  1  synchronous, active-high reset.
REQ-007 i_en  in  1  high enables new grants; low blocks new grants while in-flight jobs drain.
REQ-008 i_req_vld  in  REQ_CNT  per-requester job valid.
REQ-009 o_req_rdy  out  REQ_CNT  per-requester accept; a job transfers when vld&rdy.
REQ-010 i_req_data  in  REQ_CNT x DATA_CNT x DATA_WIDTH  per-requester unsorted vector.
REQ-011 i_req_cnt  in  REQ_CNT x CW  number of valid lanes, CW=$clog2(DATA_CNT+1).
REQ-012 o_srt_vld / o_srt_data  out  1 / DATA_CNT x DATA_WIDTH  drive the cm_sort i_vld/i_data.
REQ-013 i_srt_vld / i_srt_data  in  1 / DATA_CNT x DATA_WIDTH  from the cm_sort o_vld/o_data.
REQ-014 o_rsp_vld  out  REQ_CNT  one-hot, one-cycle pulse to the requester owning the result.
REQ-015 o_rsp_data / o_rsp_cnt  out  DATA_CNT x DATA_WIDTH / CW  shared result bus and the job's lane count.
REQ-016 o_busy  out  1  high while any job is in flight; o_err  out  1  sticky protocol error.

Function
REQ-017 Round-robin arbitration: search starts at the requester after the last granted one; at most one grant per cycle.
REQ-018 o_req_rdy shall be one-hot or zero, combinationally derived from i_req_vld, i_en and the pointer; it shall never depend on i_srt_vld.
REQ-019 The pointer shall update only on a transfer; no transfer leaves the pointer unchanged.
REQ-020 An accepted job shall appear on o_srt_vld/o_srt_data exactly 1 cycle later (registered); o_srt_vld=0 otherwise.
REQ-021 Lanes with index >= cnt shall be driven to all-ones; a cnt above DATA_CNT shall be clamped to DATA_CNT.
REQ-022 A job with cnt=0 shall be accepted and issued normally and shall return with o_rsp_cnt=0.
REQ-023 A tag {vld, id, cnt} shall enter a LAT-deep shift register in the issue cycle and shall emerge aligned with i_srt_vld.
REQ-024 When i_srt_vld=1 and the emerging tag is valid: o_rsp_vld[id]=1, o_rsp_data=i_srt_data, o_rsp_cnt=cnt, all in the same cycle (combinational, 0 added latency).
REQ-025 i_srt_vld with an invalid tag, or a valid tag without i_srt_vld, shall set o_err, which holds until reset; the response is suppressed.
REQ-026 Total latency from transfer to response: LAT+1 cycles; sustained throughput: 1 job per cycle.
REQ-027 o_busy = OR of all tag valid bits and the issue register valid.
REQ-028 When i_en falls mid-operation, in-flight jobs shall complete and respond; o_req_rdy shall be 0 from that cycle.

Reset
REQ-029 While i_rst is high: o_req_rdy=0, o_srt_vld=0, o_rsp_vld=0, o_busy=0, o_err=0, all tags invalid, pointer=0.
REQ-030 Reset mid-operation shall discard all in-flight jobs with no responses; the attached cm_sort shares i_rst.

Structure
REQ-031 The tag struct type and the CW width function shall reside in cm_pkg.
REQ-032 The round-robin arbiter shall be a separate sub-module cm_rr_arb (REQ_CNT request in, one-hot grant out, pointer update on an accept strobe).
REQ-033 The tag delay line shall be an internal shift register; no FIFO is needed, because cm_sort has no backpressure.

Verification
REQ-034 Single job, requester 2, cnt=8, data {7,3,...}, LAT=4 -> o_rsp_vld=4'b0100 at cycle 5, data ascending.
REQ-035 cnt=3, data {9,1,5,x...} -> o_rsp_data lanes 0..2 = {1,5,9}, lanes 3..7 = 16'hFFFF, o_rsp_cnt=3.
REQ-036 All 4 requesters hold vld for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 responses, back-to-back, matching ids.
REQ-037 i_en dropped after 2 grants -> no further o_req_rdy; 2 responses arrive; o_busy falls after the last one.
REQ-038 i_rst asserted with 3 jobs in flight -> no o_rsp_vld afterwards, o_busy=0, pointer=0; next job is granted to requester 0.
REQ-039 Spurious i_srt_vld injected with an empty pipeline -> o_err=1 and stays high; no o_rsp_vld.
